// File: rtl/led7seg_74hc595_rx_if.sv
// led7seg_74hc595_rx_if: 74HC595 serial link (sclk/rclk/dio) plus the receiver's decoded readback
// master: drives sclk, rclk, dio; observes latch_q, frame_valid, frame_err, digit_idx, seg_data, disp_flat
// slave: receives the link and drives the readback signals
interface led7seg_74hc595_rx_if #(
  parameter int NUM_DIGITS = 8
);
  logic sclk;
  logic rclk;
  logic dio;
  logic [15:0] latch_q;
  logic frame_valid;
  logic frame_err;
  logic [2:0] digit_idx;
  logic [7:0] seg_data;
  logic [NUM_DIGITS*8-1:0] disp_flat;
  modport master (
    output sclk, rclk, dio,
    input latch_q, frame_valid, frame_err, digit_idx, seg_data, disp_flat
  );
  modport slave (
    input sclk, rclk, dio,
    output latch_q, frame_valid, frame_err, digit_idx, seg_data, disp_flat
  );
endinterface

// File: rtl/led7seg_74hc595_rx.sv
// led7seg_74hc595_rx: oversampling receiver mirroring a two-chip 74HC595 chain, decoding latched frames into a digit buffer
// clk, rst (async, active-high); bus.slave: sclk/rclk/dio in, latch_q/frame_valid/frame_err/digit_idx/seg_data/disp_flat out
module led7seg_74hc595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS = 16,
  parameter int NUM_DIGITS = 8
) (
  input logic clk,
  input logic rst,
  led7seg_74hc595_rx_if.slave bus
);
  logic [SYNC_STAGES-1:0] sclk_sy, rclk_sy, dio_sy;
  logic sclk_p, rclk_p;
  logic [15:0] sr;
  logic [4:0] bit_cnt;
  logic sclk_r, rclk_r, dio_s, good;
  logic [2:0] idx;
  assign sclk_r = sclk_sy[SYNC_STAGES-1] & ~sclk_p;
  assign rclk_r = rclk_sy[SYNC_STAGES-1] & ~rclk_p;
  assign dio_s = dio_sy[SYNC_STAGES-1];
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) idx = sr[i] ? 3'(i) : idx;
  end
  assign good = bit_cnt == 5'(FRAME_BITS) && $onehot(sr[7:0]) && 32'(idx) < NUM_DIGITS;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sy <= '0;
      rclk_sy <= '0;
      dio_sy <= '0;
      sclk_p <= 1'b0;
      rclk_p <= 1'b0;
      sr <= '0;
      bit_cnt <= '0;
      bus.latch_q <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.digit_idx <= '0;
      bus.seg_data <= '0;
      bus.disp_flat <= '0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], bus.sclk};
      rclk_sy <= {rclk_sy[SYNC_STAGES-2:0], bus.rclk};
      dio_sy <= {dio_sy[SYNC_STAGES-2:0], bus.dio};
      sclk_p <= sclk_sy[SYNC_STAGES-1];
      rclk_p <= rclk_sy[SYNC_STAGES-1];
      bus.frame_valid <= rclk_r & good;
      bus.frame_err <= rclk_r & ~good;
      if (sclk_r) sr <= {sr[14:0], dio_s};
      if (rclk_r) begin
        // latch sees the pre-shift register; a coincident shift starts the next frame
        bus.latch_q <= sr;
        bit_cnt <= {4'b0, sclk_r};
        if (good) begin
          bus.digit_idx <= idx;
          bus.seg_data <= sr[15:8];
          bus.disp_flat[{idx, 3'b000} +: 8] <= sr[15:8];
        end
      end else if (sclk_r && bit_cnt != 5'd31) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_led7seg_74hc595_rx.sv
// tb_led7seg_74hc595_rx: directed frames with a queued scoreboard checked by an independent monitor
module tb_led7seg_74hc595_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [15:0] l;
    logic v;
    logic e;
    logic [2:0] i;
    logic [7:0] s;
    logic [63:0] d;
  } exp_t;
  exp_t q[$];
  logic [15:0] m_sr;
  int m_cnt;
  logic [2:0] m_idx;
  logic [7:0] m_seg;
  logic [63:0] m_disp;
  led7seg_74hc595_rx_if #(.NUM_DIGITS(8)) bus ();
  led7seg_74hc595_rx #(.SYNC_STAGES(2), .FRAME_BITS(16), .NUM_DIGITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (bus.frame_valid || bus.frame_err)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%b err=%b expected no pulse", bus.frame_valid, bus.frame_err);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("latch_q", 64'(bus.latch_q), 64'(x.l));
        chk("valid_err", 64'({bus.frame_valid, bus.frame_err}), 64'({x.v, x.e}));
        chk("digit_idx", 64'(bus.digit_idx), 64'(x.i));
        chk("seg_data", 64'(bus.seg_data), 64'(x.s));
        chk("disp_flat", bus.disp_flat, x.d);
      end
    end
  end
  task automatic model_reset();
    m_sr = '0;
    m_cnt = 0;
    m_idx = '0;
    m_seg = '0;
    m_disp = '0;
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      bus.dio = v[k];
      #40 bus.sclk = 1'b1;
      #40 bus.sclk = 1'b0;
      m_sr = {m_sr[14:0], v[k]};
      if (m_cnt < 31) m_cnt++;
    end
  endtask
  task automatic latch();
    exp_t x;
    int ones;
    int sel;
    logic ok;
    ones = 0;
    sel = 0;
    for (int k = 0; k < 8; k++) if (m_sr[k]) begin
      ones++;
      sel = k;
    end
    ok = (m_cnt == 16) && (ones == 1);
    if (ok) begin
      m_idx = 3'(sel);
      m_seg = m_sr[15:8];
      m_disp[sel*8 +: 8] = m_sr[15:8];
    end
    x.l = m_sr;
    x.v = ok;
    x.e = !ok;
    x.i = m_idx;
    x.s = m_seg;
    x.d = m_disp;
    q.push_back(x);
    m_cnt = 0;
    #40 bus.rclk = 1'b1;
    #40 bus.rclk = 1'b0;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got no pulse expected latch_q=%h", x.l);
      q.delete();
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_latch"}, 64'(bus.latch_q), 64'h0);
    chk({name, "_flags"}, 64'({bus.frame_valid, bus.frame_err}), 64'h0);
    chk({name, "_idx"}, 64'(bus.digit_idx), 64'h0);
    chk({name, "_seg"}, 64'(bus.seg_data), 64'h0);
    chk({name, "_disp"}, bus.disp_flat, 64'h0);
  endtask
  initial begin
    bus.sclk = 1'b0;
    bus.rclk = 1'b0;
    bus.dio = 1'b0;
    model_reset();
    #1 chk_zero("reset0");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send(32'hC001, 16);
    latch();
    send(32'hF908, 16);
    latch();
    send(32'hA480, 16);
    latch();
    send(32'h1234, 15);
    latch();
    send(32'h1_5602, 17);
    latch();
    send(32'h7705, 16);
    latch();
    send(32'h6600, 16);
    latch();
    send(32'hFFFF_FFFF, 32);
    send(32'h3F04, 16);
    latch();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("reset_async");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send(32'h00AB, 8);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send(32'h9204, 16);
    latch();
    chk("disp_digit2", 64'(bus.disp_flat[23:16]), 64'h92);
    repeat (10) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
